logic2d_packer: RTL

LOGIC2D_PACKER -- requirements
Module: logic2d_packer

---
 rtl/logic2d_packer.sv | 103 ++++++++++
 1 files changed

// File: rtl/logic2d_packer.sv
// Packs ITEM_WIDTH items into N_ITEMS-wide words, slot 0 first; optional early close via LOGIC2D_PACKER_LAST_EN.
// Latency: word presented one cycle after its final item is accepted; next word accumulates meanwhile.
// Backpressure: i_ready drops only when a held output word would be overwritten by a completing accept.
module logic2d_packer #(
    parameter int ITEM_WIDTH = 8,
    parameter int N_ITEMS    = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [ITEM_WIDTH-1:0]           i_data,
    input  logic                            i_valid,
    output logic                            i_ready,
`ifdef LOGIC2D_PACKER_LAST_EN
    input  logic                            i_last,
`endif
    output logic [N_ITEMS*ITEM_WIDTH-1:0]   o_data,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [$clog2(N_ITEMS+1)-1:0]    o_count
);

    localparam int WORD_W = N_ITEMS * ITEM_WIDTH;
    localparam int CNT_W  = $clog2(N_ITEMS);
    localparam int OCNT_W = $clog2(N_ITEMS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_ITEMS - 1);

    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic [OCNT_W-1:0] out_cnt_q, out_cnt_d;
    logic              out_vld_q, out_vld_d;

    logic [WORD_W-1:0] acc_with_item;
    logic              accept;
    logic              complete;

`ifdef LOGIC2D_PACKER_LAST_EN
    // Any accept may close a word, so a held word must always be draining.
    assign i_ready  = !out_vld_q || o_ready;
    assign complete = accept && ((acc_cnt_q == CNT_MAX) || i_last);
`else
    assign i_ready  = !out_vld_q || o_ready || (acc_cnt_q != CNT_MAX);
    assign complete = accept && (acc_cnt_q == CNT_MAX);
`endif

    assign accept = i_valid && i_ready;

    always_comb begin
        acc_with_item = acc_q;
        for (int k = 0; k < N_ITEMS; k++) begin
            if (acc_cnt_q == CNT_W'(k)) begin
                acc_with_item[k*ITEM_WIDTH +: ITEM_WIDTH] = i_data;
            end
        end
    end

    always_comb begin
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        out_d     = out_q;
        out_cnt_d = out_cnt_q;
        out_vld_d = out_vld_q;

        if (o_ready) begin
            out_vld_d = 1'b0;
        end

        if (accept) begin
            if (complete) begin
                // Completion wins over consumption: the next word follows with no bubble.
                out_d     = acc_with_item;
                out_cnt_d = OCNT_W'(acc_cnt_q) + OCNT_W'(1);
                out_vld_d = 1'b1;
                acc_d     = '0;
                acc_cnt_d = '0;
            end else begin
                acc_d     = acc_with_item;
                acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            acc_cnt_q <= '0;
            out_q     <= '0;
            out_cnt_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            out_q     <= out_d;
            out_cnt_q <= out_cnt_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign o_data  = out_q;
    assign o_count = out_cnt_q;
    assign o_valid = out_vld_q;

endmodule
